disp_hex_mux4: RTL and testbench
================================

# disp_hex_mux4

Time-multiplexed driver for a 4-digit, common-anode, seven-segment display. It takes four 4-bit hex nibbles and four decimal-point bits and scans one digit at a time. Each nibble is decoded to an active-low segment pattern, and the matching active-low anode is asserted. It sits at the top level between datapath/status logic and the board display pins.

## Interface
Parameters:
- N, default 18: refresh counter width. The top two bits select the digit. Legal range N ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- hex3  in  4  nibble for digit 3 (leftmost).
- hex2  in  4  nibble for digit 2.
- hex1  in  4  nibble for digit 1.
- hex0  in  4  nibble for digit 0 (rightmost).
- dp_in  in  4  decimal-point bits, one per digit (bit i ↔ digit i). Passed through raw, so 1 = dp off.
- an  out  4  anode enables, active-low, exactly one low while scanning.
- sseg  out  8  segments, active-low; sseg[7]=dp, sseg[6:0]={g,f,e,d,c,b,a}.

## Operation
- Free-running N-bit up counter q:
  - Increments every clock while reset is deasserted.
  - Wraps from 2^N−1 to 0.
- Digit select sel = q[N-1:N-2]:
  - 00 → an=1110, hex0, dp_in[0]
  - 01 → an=1101, hex1, dp_in[1]
  - 10 → an=1011, hex2, dp_in[2]
  - 11 → an=0111, hex3, dp_in[3]
- sseg[7] = selected dp_in bit, not inverted.
- Hex decode, sseg[6:0] as hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Inputs hex*/dp_in are sampled live: a change appears the next time the owning digit is selected, with the same one-cycle output lag as any other decode.
- No handshake. Inputs are assumed stable or synchronous to clk.

## Timing
- While reset is low: q=0, an=4'b1111 (all digits off), sseg=8'hFF (all segments off).
- Reset mid-scan: outputs blank immediately (asynchronously), and q returns to 0.
- an and sseg are registered. At each rising edge they load the decode of the pre-edge q, so outputs lag q by one cycle.
  - First edge after reset release: outputs show digit 0.
- Each digit is active for 2^(N-2) consecutive cycles. Full scan period is 2^N cycles.
- Digit 3→0 transition happens at counter wrap with no gap cycle.
- Exactly one anode is low at any time outside reset. Anodes never overlap.

## Configuration
- Macro DISP_HEX_MUX_LZB_EN enables leading-zero blanking.
  - Defined:
    - Digit 3 is blanked when hex3==0.
    - Digit 2 is blanked when hex3==0 and hex2==0.
    - Digit 1 is blanked when hex3, hex2 and hex1 are all 0.
    - Digit 0 is never blanked.
    - A blanked digit drives an=4'b1111 and sseg=8'hFF for its whole slot, dp included. The scan timing is unchanged.
  - Undefined: all four digits are always displayed, including zeros.

## Test plan
- Reset behaviour: hold reset low for 5 cycles with arbitrary inputs → an=1111, sseg=FF throughout. Assert reset low mid-scan → outputs blank the same cycle.
- Scan order, with N=4, hex3..0=4,3,2,1 and dp_in=4'hF:
  - First 4 post-reset cycles: an=1110, sseg=F9.
  - Next 4: an=1101, sseg=A4.
  - Next 4: an=1011, sseg=B0.
  - Next 4: an=0111, sseg=99.
  - Then wrap to 1110.
- Full decode: sweep hex0 through 0..F while digit 0 is selected → sseg[6:0] matches every table entry.
- Decimal point: dp_in=4'b1011 → sseg[7]=0 only during digit 2's slot.
- Mid-scan update: change hex1 from 5 to A while digit 3 is active → on digit 1's next slot, sseg[6:0]=08.
- Blanking, with DISP_HEX_MUX_LZB_EN defined and hex3..0=0,0,7,0:
  - Digit 3 and digit 2 slots: an=1111, sseg=FF.
  - Digit 1 slot: shows 78.
  - Digit 0 slot: shows 40.
  - With the macro undefined, all four digits are lit.

Source files
------------

// File: rtl/disp_hex_mux4.sv
// Four-digit common-anode seven-segment scan driver with registered, active-low outputs.
// Define DISP_HEX_MUX_LZB_EN to blank leading zero digits (digit 0 is always shown).
module disp_hex_mux4 #(
    parameter int unsigned N = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex3,
    input  logic [3:0] hex2,
    input  logic [3:0] hex1,
    input  logic [3:0] hex0,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int unsigned SEL_W = 2;

    logic [N-1:0]     q;
    logic [SEL_W-1:0] sel;
    logic [3:0]       an_c;
    logic [3:0]       digit_c;
    logic             dp_c;
    logic             blank_c;
    logic [6:0]       seg_c;

    assign sel = q[N-1 -: SEL_W];

    // Digit select: anode pattern, nibble and dp for the digit picked by the counter MSBs.
    always_comb begin
        an_c    = 4'b1111;
        digit_c = hex0;
        dp_c    = dp_in[0];
        case (sel)
            2'd0: begin an_c = 4'b1110; digit_c = hex0; dp_c = dp_in[0]; end
            2'd1: begin an_c = 4'b1101; digit_c = hex1; dp_c = dp_in[1]; end
            2'd2: begin an_c = 4'b1011; digit_c = hex2; dp_c = dp_in[2]; end
            default: begin an_c = 4'b0111; digit_c = hex3; dp_c = dp_in[3]; end
        endcase
    end

    // Leading-zero blanking: a digit is blank only if it and every digit to its left are zero.
    always_comb begin
        blank_c = 1'b0;
`ifdef DISP_HEX_MUX_LZB_EN
        case (sel)
            2'd3:    blank_c = (hex3 == 4'h0);
            2'd2:    blank_c = (hex3 == 4'h0) && (hex2 == 4'h0);
            2'd1:    blank_c = (hex3 == 4'h0) && (hex2 == 4'h0) && (hex1 == 4'h0);
            default: blank_c = 1'b0;
        endcase
`else
        blank_c = 1'b0;
`endif
    end

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        seg_c = 7'h7F;
        case (digit_c)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            default: seg_c = 7'h0E;
        endcase
    end

    // Refresh counter and output registers; outputs trail the counter by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            an   <= 4'b1111;
            sseg <= 8'hFF;
        end else begin
            q <= q + N'(1);
            if (blank_c) begin
                an   <= 4'b1111;
                sseg <= 8'hFF;
            end else begin
                an   <= an_c;
                sseg <= {dp_c, seg_c};
            end
        end
    end

endmodule

// File: tb/tb_disp_hex_mux4.sv
// Directed self-checking bench for disp_hex_mux4 with a 4-bit refresh counter (4 cycles per digit).
// Blanking expectations follow DISP_HEX_MUX_LZB_EN when the bench is built with it.
module tb_disp_hex_mux4;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [7:0] sseg;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16];
    logic [3:0] scan_an  [4];
    logic [7:0] scan_seg [4];

    disp_hex_mux4 #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .dp_in (dp_in),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'b1111;
        a[d[1:0]] = 1'b0;
        return a;
    endfunction

    function automatic logic [3:0] hex_of(input int d);
        case (d)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            default: return hex3;
        endcase
    endfunction

    function automatic logic blank_of(input int d);
`ifdef DISP_HEX_MUX_LZB_EN
        case (d)
            3: return hex3 == 4'h0;
            2: return (hex3 == 4'h0) && (hex2 == 4'h0);
            1: return (hex3 == 4'h0) && (hex2 == 4'h0) && (hex1 == 4'h0);
            default: return 1'b0;
        endcase
`else
        return (d < 0);
`endif
    endfunction

    // Expected outputs after edge k (counted from reset release) come from the bench's input copy.
    task automatic scan_check(input string tag, input int start, input int count);
        int d;
        for (int k = start; k < start + count; k++) begin
            tick();
            d = (k / 4) % 4;
            if (blank_of(d)) begin
                check({tag, "_an"},   {4'h0, an}, 8'h0F);
                check({tag, "_sseg"}, sseg,       8'hFF);
            end else begin
                check({tag, "_an"},   {4'h0, an}, {4'h0, an_of(d)});
                check({tag, "_sseg"}, sseg,       {dp_in[d], seg_tab[hex_of(d)]});
            end
        end
    endtask

    // Enter reset at a falling edge, confirm immediate blanking, release at a later falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst_an"},   {4'h0, an}, 8'h0F);
        check({tag, "_rst_sseg"}, sseg,       8'hFF);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_seg = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

        reset = 1'b0;
        hex3 = 4'hA; hex2 = 4'hB; hex1 = 4'hC; hex0 = 4'hD;
        dp_in = 4'h5;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rst_an",   {4'h0, an}, 8'h0F);
            check("hold_rst_sseg", sseg,       8'hFF);
        end

        hex3 = 4'h4; hex2 = 4'h3; hex1 = 4'h2; hex0 = 4'h1;
        dp_in = 4'hF;
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("scan_an",   {4'h0, an}, {4'h0, scan_an[k / 4]});
            check("scan_sseg", sseg,       scan_seg[k / 4]);
        end
        tick();
        check("wrap_an",   {4'h0, an}, 8'h0E);
        check("wrap_sseg", sseg,       8'hF9);

        tick();
        tick();
        do_reset("midscan");
        tick();
        check("restart_an",   {4'h0, an}, 8'h0E);
        check("restart_sseg", sseg,       8'hF9);

        @(negedge clk);
        do_reset("decode");
        for (int v = 0; v < 16; v++) begin
            hex0 = 4'(v);
            tick();
            check("decode_an",   {4'h0, an}, 8'h0E);
            check("decode_sseg", sseg,       {1'b1, seg_tab[v]});
            repeat (15) tick();
        end

        dp_in = 4'b1011;
        do_reset("dp");
        scan_check("dp", 0, 16);

        hex3 = 4'h4; hex2 = 4'h3; hex1 = 4'h5; hex0 = 4'h1;
        dp_in = 4'hF;
        do_reset("update");
        scan_check("update_pre", 0, 14);
        hex1 = 4'hA;
        scan_check("update_mid", 14, 6);
        for (int k = 20; k < 24; k++) begin
            tick();
            check("update_an",  {4'h0, an},   8'h0D);
            check("update_seg", {1'b0, sseg[6:0]}, 8'h08);
        end

        hex3 = 4'h0; hex2 = 4'h0; hex1 = 4'h7; hex0 = 4'h0;
        do_reset("blank");
        scan_check("blank", 0, 16);
        tick();
        check("blank_d0_seg", sseg, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
